// File: rtl/icache_ctrl_pkg.sv
// Shared geometry, FSM encoding and reset constants for the instruction cache.
// The optional ICACHE_STATS_EN counters need nothing from this package.
package icache_ctrl_pkg;

   localparam int NUM_BLOCKS  = 8;
   localparam int BLOCK_WORDS = 4;
   localparam int ADDR_W      = 10;

   localparam int INDEX_W    = $clog2(NUM_BLOCKS);
   localparam int OFFSET_W   = $clog2(BLOCK_WORDS);
   localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W - 2;
   localparam int BLOCK_BITS = 32 * BLOCK_WORDS;
   // Block address sent to memory is {tag,index}.
   localparam int MEM_ADDR_W = TAG_W + INDEX_W;

   localparam logic [31:0] INSTR_RST = 32'h0;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_READ = 2'd1,
      S_UPDATE   = 2'd2
   } state_e;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational lookup of one word; one-cycle whole-line write.
module icache_line_array
   import icache_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_W-1:0]    rd_index,
   input  logic [TAG_W-1:0]      rd_tag,
   input  logic [OFFSET_W-1:0]   rd_offset,
   output logic                  rd_match,
   output logic [31:0]           rd_word,
   input  logic                  wr_en,
   input  logic [INDEX_W-1:0]    wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [BLOCK_BITS-1:0] wr_data
);

   logic [NUM_BLOCKS-1:0] valid;
   logic [TAG_W-1:0]      tag_store  [NUM_BLOCKS];
   logic [BLOCK_BITS-1:0] data_store [NUM_BLOCKS];
   logic [BLOCK_BITS-1:0] rd_block;

   // Only the valid bits need clearing; tag and data are don't-care until valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_store[wr_index]  <= wr_tag;
         data_store[wr_index] <= wr_data;
      end
   end

   assign rd_block = data_store[rd_index];
   assign rd_match = valid[rd_index] && (tag_store[rd_index] == rd_tag);
   assign rd_word  = rd_block[rd_offset*32 +: 32];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller (IDLE/MEM_READ/UPDATE).
// Define ICACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT outputs.
module icache_ctrl
   import icache_ctrl_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic [ADDR_W-1:0]     ADDRESS,
   output logic [31:0]           INSTRUCTION,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   input  logic [BLOCK_BITS-1:0] MEM_READDATA,
   input  logic                  MEM_BUSYWAIT,
   output logic [1:0]            dbg_state
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]           HIT_COUNT,
   output logic [15:0]           MISS_COUNT
`endif
);

   // Handshakes: a fetch is served in the cycle READ=1 and BUSYWAIT=0, with
   // INSTRUCTION valid in that cycle; MEM_READ is held until the first cycle
   // MEM_BUSYWAIT=0, in which MEM_READDATA is valid and captured on the edge.

   state_e                state, state_nxt;
   logic [OFFSET_W-1:0]   cpu_offset;
   logic [INDEX_W-1:0]    cpu_index;
   logic [TAG_W-1:0]      cpu_tag;
   logic                  unused_byte;
   logic                  rd_match;
   logic [31:0]           rd_word;
   logic                  miss_start;
   logic                  cpu_served;
   logic                  line_wr;
   logic [MEM_ADDR_W-1:0] fill_addr;
   logic [BLOCK_BITS-1:0] fill_data;
   logic [31:0]           last_instr;

   assign cpu_offset  = ADDRESS[OFFSET_W+1:2];
   assign cpu_index   = ADDRESS[INDEX_W+OFFSET_W+1:OFFSET_W+2];
   assign cpu_tag     = ADDRESS[ADDR_W-1:ADDR_W-TAG_W];
   assign unused_byte = ^ADDRESS[1:0];

   icache_line_array u_lines (
      .clk       (CLK),
      .rst_n     (RESET),
      .rd_index  (cpu_index),
      .rd_tag    (cpu_tag),
      .rd_offset (cpu_offset),
      .rd_match  (rd_match),
      .rd_word   (rd_word),
      .wr_en     (line_wr),
      .wr_index  (fill_addr[INDEX_W-1:0]),
      .wr_tag    (fill_addr[MEM_ADDR_W-1:INDEX_W]),
      .wr_data   (fill_data)
   );

   assign miss_start = (state == S_IDLE) && READ && !rd_match;
   assign cpu_served = (state == S_IDLE) && READ && rd_match;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (miss_start) state_nxt = S_MEM_READ;
         S_MEM_READ: if (!MEM_BUSYWAIT) state_nxt = S_UPDATE;
         S_UPDATE:   state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      BUSYWAIT = 1'b0;
      MEM_READ = 1'b0;
      line_wr  = 1'b0;
      case (state)
         S_IDLE:     BUSYWAIT = miss_start;
         S_MEM_READ: begin
            BUSYWAIT = 1'b1;
            MEM_READ = 1'b1;
         end
         S_UPDATE:   begin
            BUSYWAIT = 1'b1;
            line_wr  = 1'b1;
         end
         default:    ;
      endcase
      // The stall must drop while reset is held, even with READ high.
      if (!RESET) BUSYWAIT = 1'b0;
      INSTRUCTION = cpu_served ? rd_word : last_instr;
   end

   // The fill block address is frozen at miss entry so CPU address changes
   // during the fill cannot redirect it.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         fill_addr  <= '0;
         fill_data  <= '0;
         last_instr <= INSTR_RST;
      end else begin
         if (miss_start) fill_addr <= {cpu_tag, cpu_index};
         if (state == S_MEM_READ && !MEM_BUSYWAIT) fill_data <= MEM_READDATA;
         if (cpu_served) last_instr <= rd_word;
      end
   end

   assign MEM_ADDRESS = fill_addr;
   assign dbg_state   = state;

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         HIT_COUNT  <= '0;
         MISS_COUNT <= '0;
      end else begin
         if (cpu_served && HIT_COUNT != 16'hFFFF) HIT_COUNT <= HIT_COUNT + 16'd1;
         if (miss_start && MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a latency-5 block memory model and an
// expected-instruction queue; stats checks are built when ICACHE_STATS_EN is set.
module tb_icache_ctrl;
   import icache_ctrl_pkg::*;

   localparam int MEM_LAT = 5;

   logic                  CLK;
   logic                  RESET;
   logic                  READ;
   logic [ADDR_W-1:0]     ADDRESS;
   logic [31:0]           INSTRUCTION;
   logic                  BUSYWAIT;
   logic                  MEM_READ;
   logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
   logic [BLOCK_BITS-1:0] MEM_READDATA;
   logic                  MEM_BUSYWAIT;
   logic [1:0]            dbg_state;
`ifdef ICACHE_STATS_EN
   logic [15:0]           HIT_COUNT;
   logic [15:0]           MISS_COUNT;
`endif

   logic [31:0] exp_q[$];
   int pass_cnt  = 0;
   int total_cnt = 0;
   int mem_cnt;

   icache_ctrl dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .READ         (READ),
      .ADDRESS      (ADDRESS),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT),
      .dbg_state    (dbg_state)
`ifdef ICACHE_STATS_EN
      ,
      .HIT_COUNT    (HIT_COUNT),
      .MISS_COUNT   (MISS_COUNT)
`endif
   );

   // Clock / reset-independent watchdog
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Reference content: word w of block b is {b in [21:16], 'hA + w}.
   function automatic logic [31:0] model_word(input logic [ADDR_W-1:0] a);
      logic [31:0] w;
      w = 32'h0000_000A + {30'd0, a[3:2]};
      w[21:16] = a[9:4];
      return w;
   endfunction

   function automatic logic [BLOCK_BITS-1:0] model_block(input logic [MEM_ADDR_W-1:0] blk);
      logic [BLOCK_BITS-1:0] b;
      for (int w = 0; w < BLOCK_WORDS; w++) begin
         logic [1:0] wi;
         wi = w[1:0];
         b[w*32 +: 32] = model_word({blk, wi, 2'b00});
      end
      return b;
   endfunction

   // Instruction memory model: busy for MEM_LAT-1 cycles of MEM_READ, data in the last.
   always @(posedge CLK or negedge RESET) begin
      if (!RESET) mem_cnt <= 0;
      else if (MEM_READ) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
   end

   assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < MEM_LAT - 1);
   assign MEM_READDATA = (MEM_READ && !MEM_BUSYWAIT) ? model_block(MEM_ADDRESS)
                                                     : {4{32'hDEAD_BEEF}};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Waits (bounded) for the fetch to be served, then pops and compares.
   task automatic serve(input string tag, input int exp_busy, input bit exp_mem,
                        input logic [MEM_ADDR_W-1:0] exp_madr);
      int busy;
      bit saw_mem;
      logic [MEM_ADDR_W-1:0] madr;
      logic [31:0] exp;
      busy    = 0;
      saw_mem = 1'b0;
      madr    = '0;
      #1;
      while (BUSYWAIT === 1'b1 && busy < 60) begin
         busy++;
         if (MEM_READ === 1'b1) begin
            saw_mem = 1'b1;
            madr    = MEM_ADDRESS;
         end
         @(negedge CLK);
         #1;
      end
      check({tag, ".busy"}, busy, exp_busy);
      check({tag, ".memrd_seen"}, {31'd0, saw_mem}, {31'd0, exp_mem});
      if (exp_mem) check({tag, ".mem_addr"}, {26'd0, madr}, {26'd0, exp_madr});
      check({tag, ".memrd_now"}, {31'd0, MEM_READ}, 32'd0);
      exp = exp_q.pop_front();
      check({tag, ".instr"}, INSTRUCTION, exp);
      @(negedge CLK);
   endtask

   task automatic fetch(input string tag, input logic [ADDR_W-1:0] a, input int exp_busy,
                        input bit exp_mem, input logic [MEM_ADDR_W-1:0] exp_madr);
      READ    = 1'b1;
      ADDRESS = a;
      exp_q.push_back(model_word(a));
      serve(tag, exp_busy, exp_mem, exp_madr);
   endtask

   initial begin
      RESET   = 1'b0;
      READ    = 1'b0;
      ADDRESS = '0;
      repeat (2) @(negedge CLK);
      #1;
      check("rst.instr", INSTRUCTION, 32'h0);
      check("rst.busy", {31'd0, BUSYWAIT}, 32'd0);
      check("rst.memrd", {31'd0, MEM_READ}, 32'd0);
      check("rst.madr", {26'd0, MEM_ADDRESS}, 32'd0);
      check("rst.state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      READ = 1'b1;
      #1;
      check("rst.busy_read", {31'd0, BUSYWAIT}, 32'd0);
      READ = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);

      // Cold miss then same-block hits
      fetch("cold", 10'h000, 7, 1'b1, 6'h00);
      fetch("hit4", 10'h004, 0, 1'b0, 6'h00);
      fetch("hit8", 10'h008, 0, 1'b0, 6'h00);
      fetch("hitC", 10'h00C, 0, 1'b0, 6'h00);
`ifdef ICACHE_STATS_EN
      check("stats.miss1", {16'd0, MISS_COUNT}, 32'd1);
      check("stats.hit4", {16'd0, HIT_COUNT}, 32'd4);
`endif

      // READ low holds outputs and starts nothing
      READ    = 1'b0;
      ADDRESS = 10'h3F0;
      #1;
      check("hold.instr", INSTRUCTION, 32'h0000_000D);
      check("hold.busy", {31'd0, BUSYWAIT}, 32'd0);
      @(negedge CLK);
      #1;
      check("hold.memrd", {31'd0, MEM_READ}, 32'd0);
      check("hold.state", {30'd0, dbg_state}, {30'd0, S_IDLE});

      // Conflict eviction on index 0
      fetch("evict80", 10'h080, 7, 1'b1, 6'h08);
      fetch("refill0", 10'h000, 7, 1'b1, 6'h00);
      fetch("evict84", 10'h084, 7, 1'b1, 6'h08);

      // Reset two cycles into MEM_READ
      READ    = 1'b1;
      ADDRESS = 10'h040;
      @(negedge CLK);
      @(negedge CLK);
      #1;
      check("rstfill.memrd_pre", {31'd0, MEM_READ}, 32'd1);
      check("rstfill.madr_pre", {26'd0, MEM_ADDRESS}, 32'h04);
      RESET = 1'b0;
      #1;
      check("rstfill.memrd", {31'd0, MEM_READ}, 32'd0);
      check("rstfill.busy", {31'd0, BUSYWAIT}, 32'd0);
      check("rstfill.state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      check("rstfill.instr", INSTRUCTION, 32'h0);
      @(negedge CLK);
      RESET = 1'b1;
      fetch("post_rst", 10'h000, 7, 1'b1, 6'h00);

      // Address change mid-fill: line 1 fills, then line 2 misses
      READ    = 1'b1;
      ADDRESS = 10'h010;
      exp_q.push_back(model_word(10'h020));
      #1;
      check("chg.busy0", {31'd0, BUSYWAIT}, 32'd1);
      @(negedge CLK);
      #1;
      check("chg.madr1", {26'd0, MEM_ADDRESS}, 32'h01);
      @(negedge CLK);
      ADDRESS = 10'h020;
      serve("chg", 12, 1'b1, 6'h02);
      fetch("line1", 10'h010, 0, 1'b0, 6'h00);
      fetch("line1w1", 10'h014, 0, 1'b0, 6'h00);

`ifdef ICACHE_STATS_EN
      READ    = 1'b1;
      ADDRESS = 10'h010;
      repeat (70000) @(negedge CLK);
      #1;
      check("stats.hit_sat", {16'd0, HIT_COUNT}, 32'h0000_FFFF);
      check("stats.miss3", {16'd0, MISS_COUNT}, 32'd3);
`endif

      READ = 1'b0;
      @(negedge CLK);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
